// File: rtl/idx2mask_stream_if.sv
// Handshake bundle for idx2mask_stream: input beat stream, decode mode and registered mask output.
// slave is the decoder's view of the bundle; master is the producer/consumer side that drives it.
interface idx2mask_stream_if #(
    parameter int IDX_WIDTH = 4,
    parameter int LANES     = 4
);
    localparam int OH_WIDTH = 1 << IDX_WIDTH;

    logic [1:0]                  mode;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*IDX_WIDTH-1:0]  in_idx;
    logic [LANES-1:0]            in_lane_en;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*OH_WIDTH-1:0]   out_data;
    logic                        out_last;
    logic [IDX_WIDTH:0]          out_pop;

    modport slave (
        input  mode, in_valid, in_idx, in_lane_en, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_pop
    );

    modport master (
        output mode, in_valid, in_idx, in_lane_en, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_pop
    );
endinterface

// File: rtl/idx2mask_stream.sv
// Multi-lane index to one-hot/thermometer/occupancy-bitmap decoder behind a valid/ready output register.
// Define IDX2MASK_POPCNT_EN to drive out_pop with the population count of lane 0; otherwise out_pop is 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | next accepted beat starts a burst and samples mode
// BURST   | inside a multi-beat burst, mode held in r_mode_q
module idx2mask_stream #(
    parameter int IDX_WIDTH = 4,
    parameter int LANES     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    idx2mask_stream_if.slave   io_bus
);
    localparam int OH_WIDTH = 1 << IDX_WIDTH;
    localparam int DW       = LANES * OH_WIDTH;

    localparam logic [1:0] MODE_THERM = 2'b01;
    localparam logic [1:0] MODE_ACC   = 2'b10;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_mode_q;
    logic [1:0]            w_mode_eff;
    logic [OH_WIDTH-1:0]   r_acc;
    logic [OH_WIDTH-1:0]   w_acc_nxt;
    logic [OH_WIDTH-1:0]   w_beat_or;
    logic [DW-1:0]         w_oh_mask;
    logic [DW-1:0]         w_th_mask;
    logic [DW-1:0]         w_data_nxt;
    logic [IDX_WIDTH:0]    w_pop_nxt;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DW-1:0]         r_out_data;
    logic [IDX_WIDTH:0]    r_out_pop;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_is_acc;
    logic                  w_produce;

    assign w_in_ready = !r_out_valid || io_bus.out_ready;
    assign w_accept   = io_bus.in_valid && w_in_ready;
    assign w_mode_eff = (r_state == ST_IDLE) ? io_bus.mode : r_mode_q;
    assign w_is_acc   = (w_mode_eff == MODE_ACC);
    assign w_produce  = w_accept && (!w_is_acc || io_bus.in_last);

    always_comb begin
        w_oh_mask = '0;
        w_th_mask = '0;
        w_beat_or = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int b = 0; b < OH_WIDTH; b++) begin
                w_oh_mask[k*OH_WIDTH+b] = io_bus.in_lane_en[k] &&
                    (io_bus.in_idx[k*IDX_WIDTH +: IDX_WIDTH] == IDX_WIDTH'(b));
                w_th_mask[k*OH_WIDTH+b] = io_bus.in_lane_en[k] &&
                    (IDX_WIDTH'(b) <= io_bus.in_idx[k*IDX_WIDTH +: IDX_WIDTH]);
            end
            w_beat_or = w_beat_or | w_oh_mask[k*OH_WIDTH +: OH_WIDTH];
        end
    end

    // Reserved mode 11 falls through to one-hot.
    always_comb begin
        w_data_nxt = '0;
        if (w_is_acc) begin
            w_data_nxt[OH_WIDTH-1:0] = r_acc | w_beat_or;
        end else if (w_mode_eff == MODE_THERM) begin
            w_data_nxt = w_th_mask;
        end else begin
            w_data_nxt = w_oh_mask;
        end
    end

`ifdef IDX2MASK_POPCNT_EN
    always_comb begin
        w_pop_nxt = '0;
        for (int b = 0; b < OH_WIDTH; b++) begin
            w_pop_nxt = w_pop_nxt + (IDX_WIDTH+1)'(w_data_nxt[b]);
        end
    end
`else
    assign w_pop_nxt = '0;
`endif

    always_comb begin
        w_acc_nxt = r_acc;
        if (w_accept && w_is_acc) begin
            w_acc_nxt = io_bus.in_last ? '0 : (r_acc | w_beat_or);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && !io_bus.in_last) w_state_nxt = ST_BURST;
            ST_BURST: if (w_accept && io_bus.in_last)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mode_q <= 2'b00;
            r_acc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            if (w_accept && r_state == ST_IDLE) begin
                r_mode_q <= io_bus.mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_pop   <= '0;
        end else if (w_produce) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data_nxt;
            r_out_last  <= io_bus.in_last;
            r_out_pop   <= w_pop_nxt;
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.out_pop   = r_out_pop;
endmodule

// File: tb/tb_idx2mask_stream.sv
// Bench for idx2mask_stream: vector table, directed burst/backpressure/reset sequences, random scoreboard.
module tb_idx2mask_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    idx2mask_stream_if #(.IDX_WIDTH(4), .LANES(4)) bus ();
    idx2mask_stream #(.IDX_WIDTH(4), .LANES(4)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] idx;
        logic [3:0]  en;
        logic [63:0] exp_data;
        logic [4:0]  exp_pop;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [4:0]  pop;
    } beat_t;

    vec_t  vecs[8];
    beat_t sbq[$];

    function automatic logic [4:0] popx(input logic [4:0] p);
`ifdef IDX2MASK_POPCNT_EN
        return p;
`else
        return 5'd0 & p;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [15:0] idx, input logic [3:0] en,
                         input logic last);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.mode = m; bus.in_idx = idx; bus.in_lane_en = en; bus.in_last = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [63:0] d, input logic [4:0] p);
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_data"},  bus.out_data, d);
        chk({nm, "_last"},  64'(bus.out_last), 64'd1);
        chk({nm, "_pop"},   64'(bus.out_pop), 64'(popx(p)));
    endtask

    // Reference: decode from the rules directly; mode held for the whole burst.
    logic        m_burst;
    logic [1:0]  m_mode;
    logic [15:0] m_acc;

    task automatic model_beat(input logic [1:0] mode, input logic [15:0] idx, input logic [3:0] en,
                              input logic last);
        beat_t       e;
        logic [1:0]  eff;
        logic [3:0]  ix;
        logic [31:0] lane;
        if (!m_burst) m_mode = mode;
        eff = (m_mode == 2'b11) ? 2'b00 : m_mode;
        e.data = '0;
        e.last = last;
        for (int k = 0; k < 4; k++) begin
            ix = idx[k*4 +: 4];
            if (eff == 2'b10) begin
                if (en[k]) m_acc = m_acc | 16'(32'd1 << ix);
            end else if (en[k]) begin
                lane = (eff == 2'b01) ? ((32'd2 << ix) - 32'd1) : (32'd1 << ix);
                e.data[k*16 +: 16] = lane[15:0];
            end
        end
        if (eff == 2'b10) begin
            if (last) begin
                e.data[15:0] = m_acc;
                m_acc = '0;
                e.pop = popx(5'($countones(e.data[15:0])));
                sbq.push_back(e);
            end
        end else begin
            e.pop = popx(5'($countones(e.data[15:0])));
            sbq.push_back(e);
        end
        m_burst = !last;
    endtask

    initial begin
        bit          prev_stall;
        logic [63:0] prev_data;
        logic        prev_last;
        logic [4:0]  prev_pop;
        logic [1:0]  r_mode;
        logic [15:0] r_idx;
        logic [3:0]  r_en;
        logic        r_last;
        beat_t       e;

        vecs[0] = '{2'b00, 16'h7F03, 4'b1111, 64'h0080_8000_0001_0008, 5'd1};
        vecs[1] = '{2'b01, 16'h0005, 4'b0001, 64'h0000_0000_0000_003F, 5'd6};
        vecs[2] = '{2'b11, 16'h7F03, 4'b1111, 64'h0080_8000_0001_0008, 5'd1};
        vecs[3] = '{2'b01, 16'h270F, 4'b1111, 64'h0007_00FF_0001_FFFF, 5'd16};
        vecs[4] = '{2'b00, 16'h4321, 4'b0101, 64'h0000_0008_0000_0002, 5'd1};
        vecs[5] = '{2'b10, 16'h0944, 4'b0111, 64'h0000_0000_0000_0210, 5'd2};
        vecs[6] = '{2'b01, 16'h0000, 4'b1111, 64'h0001_0001_0001_0001, 5'd1};
        vecs[7] = '{2'b00, 16'hABCD, 4'b0000, 64'h0000_0000_0000_0000, 5'd0};

        bus.in_valid = 1'b0; bus.mode = 2'b00; bus.in_idx = '0; bus.in_lane_en = '0;
        bus.in_last = 1'b0; bus.out_ready = 1'b1;

        #12;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data",  bus.out_data, 64'd0);
        chk("rst_last",  64'(bus.out_last), 64'd0);
        chk("rst_pop",   64'(bus.out_pop), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].mode, vecs[i].idx, vecs[i].en, 1'b1);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_pop);
        end

        drive(2'b10, 16'h0021, 4'b0011, 1'b0);
        chk("acc_b0_valid", 64'(bus.out_valid), 64'd0);
        drive(2'b10, 16'h0092, 4'b0011, 1'b0);
        chk("acc_b1_valid", 64'(bus.out_valid), 64'd0);
        drive(2'b10, 16'h000F, 4'b0001, 1'b1);
        chk_out("acc_burst", 64'h0000_0000_0000_8206, 5'd4);

        drive(2'b10, 16'h0003, 4'b0001, 1'b0);
        chk("modechg_b0_valid", 64'(bus.out_valid), 64'd0);
        drive(2'b00, 16'h0005, 4'b0001, 1'b1);
        chk_out("modechg", 64'h0000_0000_0000_0028, 5'd2);

        drive(2'b00, 16'h0001, 4'b0001, 1'b1);
        chk_out("bp_a", 64'h2, 5'd1);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.mode = 2'b00; bus.in_idx = 16'h0002; bus.in_lane_en = 4'b0001;
        bus.in_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_ready%0d", c), 64'(bus.in_ready), 64'd0);
            chk($sformatf("bp_hold%0d", c), bus.out_data, 64'h2);
            chk($sformatf("bp_valid%0d", c), 64'(bus.out_valid), 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_idx = 16'h0003;
        chk_out("bp_b", 64'h4, 5'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_out("bp_c", 64'h8, 5'd1);
        @(posedge clk);
        #1;
        chk("bp_drain_valid", 64'(bus.out_valid), 64'd0);

        drive(2'b10, 16'h0001, 4'b0001, 1'b0);
        drive(2'b10, 16'h0002, 4'b0001, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_data",  bus.out_data, 64'd0);
        chk("midrst_last",  64'(bus.out_last), 64'd0);
        chk("midrst_pop",   64'(bus.out_pop), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b10, 16'h0004, 4'b0001, 1'b1);
        chk_out("midrst_after", 64'h0000_0000_0000_0010, 5'd1);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_burst = 1'b0; m_mode = 2'b00; m_acc = '0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; prev_pop = '0;

        for (int c = 0; c < 2010; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("rnd_hold_valid", 64'(bus.out_valid), 64'd1);
                chk("rnd_hold_data",  bus.out_data, prev_data);
                chk("rnd_hold_last",  64'(bus.out_last), 64'(prev_last));
                chk("rnd_hold_pop",   64'(bus.out_pop), 64'(prev_pop));
            end
            r_mode = 2'($urandom_range(0, 3));
            r_idx  = 16'($urandom());
            r_en   = 4'($urandom_range(0, 15));
            r_last = ($urandom_range(0, 3) == 0);
            bus.mode = r_mode; bus.in_idx = r_idx; bus.in_lane_en = r_en; bus.in_last = r_last;
            if (c < 2000) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            #1;
            chk("rnd_in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rnd_unexpected: got beat %h want none", bus.out_data);
                end else begin
                    e = sbq.pop_front();
                    chk("rnd_data", bus.out_data, e.data);
                    chk("rnd_last", 64'(bus.out_last), 64'(e.last));
                    chk("rnd_pop",  64'(bus.out_pop), 64'(e.pop));
                end
            end
            if (bus.in_valid && bus.in_ready) model_beat(r_mode, r_idx, r_en, r_last);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            prev_pop   = bus.out_pop;
        end
        chk("rnd_sb_empty", 64'(sbq.size()), 64'd0);
        chk("rnd_final_valid", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
